xpb_table_gen: RTL and testbench
================================

Name: xpb_table_gen

Overview:
- Runtime generator for the reduction lookup tables used by the modular-square datapath.
- Given a modulus N and a bit position s, computes the entries k·2^s mod N for k = 0 .. 2^DIGIT_BITS−1.
- Streams the entries out over a valid/ready interface to whatever writes the table RAM.
- It is the producer side of the fixed digit→residue ROMs, so tables can be rebuilt per modulus instead of resynthesised.

Parameters:
- WIDTH, 1024, modulus and entry width in bits.
- DIGIT_BITS, 5, index width; 2^DIGIT_BITS entries are generated.
- SHIFT_W, 11, width of the shift-amount input.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- modulus  in  WIDTH  N; sampled on an accepted start.
- shift_amt  in  SHIFT_W  s; sampled on an accepted start.
- busy  out  1  high from the cycle after an accepted start until the DONE state.
- out_valid  out  1  entry available.
- out_ready  in  1  sink accepts entry.
- out_index  out  DIGIT_BITS  k of the current entry.
- out_data  out  WIDTH  k·2^s mod N.
- done  out  1  one-cycle pulse after the last entry is accepted.
- err  out  1  see Optional Feature; tied 0 when the feature is compiled out.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; busy=0, out_valid=0, out_index=0, out_data=0, done=0, err=0; internal registers cleared.
- Asserting reset mid-operation aborts immediately; no partial entries are presented after release.

States:
- IDLE: on start=1, latch N and s, set base=1 mod N (0 if N==1), then go to DOUBLE if s≠0, else to EMIT. start is ignored in every other state.
- DOUBLE: one step per cycle: t = 2·base (WIDTH+1 bits); base = (t ≥ N) ? t−N : t. Runs exactly s cycles, tracked by a down-counter loaded with s, then goes to EMIT with acc=0, k=0.
- EMIT:
  - out_valid=1; out_index=k; out_data=acc.
  - On out_valid && out_ready: if k = 2^DIGIT_BITS−1, go to DONE; else k+1, and acc = (acc+base ≥ N) ? acc+base−N : acc+base, computed at WIDTH+1 bits.
  - While out_valid && !out_ready, out_index and out_data stay stable.
- DONE: done=1 for one cycle, busy=0, return to IDLE.

Timing:
- Latency from start to the first out_valid is s+1 cycles; the first entry is always k=0, data 0.
- At full throughput (out_ready held 1), entries come out one per cycle: 2^DIGIT_BITS cycles plus 1 cycle for done.

Arithmetic:
- Compare and subtract use full WIDTH+1 bit precision, so no carry is lost for N close to 2^WIDTH.
- All outputs are < N given N ≥ 2.
- Results for N < 2 are unspecified unless the check feature is enabled.

Optional Feature:
- Macro XPB_GEN_MOD_CHECK_EN.
- With the macro defined: on an accepted start with modulus < 2, no entries are emitted. The block goes IDLE→DONE, raises done together with err=1 for one cycle, and never raises busy.
- err is otherwise 0, and cleared on the next accepted start.
- With the macro undefined: no check is made and err is constant 0.

Test Plan:
- WIDTH=16, N=0xFFF1, s=16, out_ready=1 → first valid 17 cycles after start; entries k·0x000F (0x0000, 0x000F, … 0x01D1 at k=31); done 1 cycle after k=31.
- WIDTH=16, N=0x0007, s=3, out_ready=1 → base=1; out_data for k=0..7 = 0,1,2,3,4,5,6,0, and the sequence keeps wrapping mod 7 up to k=31.
- Backpressure: N=0xFFF1, s=16, out_ready toggled randomly → every entry delivered exactly once, in order, with data/index stable while stalled.
- s=0, N=0xFFF1 → base=1, first valid 1 cycle after start, out_data=k; start pulsed during EMIT is ignored.
- Reset asserted mid-DOUBLE (N=0xFFF1, s=16) → all outputs 0 immediately; a fresh start afterwards gives the full correct sequence.
- With XPB_GEN_MOD_CHECK_EN, N=1 → no out_valid, done=1 and err=1 on the same cycle; WIDTH=1024, s=870 against a golden bignum model → all 32 entries match.

Source files
------------

// File: rtl/xpb_table_gen.sv
// Streams the reduction table entries k*2^s mod N (k = 0 .. 2^DIGIT_BITS-1) over valid/ready.
// Optional modulus sanity check (N < 2 rejected with err) is compiled in by XPB_GEN_MOD_CHECK_EN.
module xpb_table_gen #(
  parameter int WIDTH      = 1024,
  parameter int DIGIT_BITS = 5,
  parameter int SHIFT_W    = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      modulus,
  input  logic [SHIFT_W-1:0]    shift_amt,
  output logic                  busy,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIGIT_BITS-1:0] out_index,
  output logic [WIDTH-1:0]      out_data,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DOUBLE = 2'd1,
    ST_EMIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0]      W_ZERO  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]      W_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DIGIT_BITS-1:0] K_ZERO  = {DIGIT_BITS{1'b0}};
  localparam logic [DIGIT_BITS-1:0] K_ONE   = {{(DIGIT_BITS-1){1'b0}}, 1'b1};
  localparam logic [DIGIT_BITS-1:0] K_LAST  = {DIGIT_BITS{1'b1}};
  localparam logic [SHIFT_W-1:0]    C_ZERO  = {SHIFT_W{1'b0}};
  localparam logic [SHIFT_W-1:0]    C_ONE   = {{(SHIFT_W-1){1'b0}}, 1'b1};

  // Single conditional subtract; t is one bit wider than N so a carry out of WIDTH is never lost.
  function automatic logic [WIDTH-1:0] mod_reduce(input logic [WIDTH:0] t, input logic [WIDTH-1:0] n);
    logic [WIDTH:0] n_ext;
    logic [WIDTH:0] diff;
    n_ext = {1'b0, n};
    diff  = t - n_ext;
    if (t >= n_ext) begin
      mod_reduce = diff[WIDTH-1:0];
    end else begin
      mod_reduce = t[WIDTH-1:0];
    end
  endfunction

  state_t                state_r, state_next_s;
  logic [WIDTH-1:0]      mod_r, mod_next_s;
  logic [WIDTH-1:0]      base_r, base_next_s;
  logic [WIDTH-1:0]      acc_r, acc_next_s;
  logic [DIGIT_BITS-1:0] k_r, k_next_s;
  logic [SHIFT_W-1:0]    cnt_r, cnt_next_s;
  logic                  reject_s;

`ifdef XPB_GEN_MOD_CHECK_EN
  assign reject_s = (modulus[WIDTH-1:1] == {(WIDTH-1){1'b0}});
`else
  assign reject_s = 1'b0;
`endif

  // Next-state and datapath update.
  always_comb begin
    state_next_s = state_r;
    mod_next_s   = mod_r;
    base_next_s  = base_r;
    acc_next_s   = acc_r;
    k_next_s     = k_r;
    cnt_next_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          mod_next_s  = modulus;
          base_next_s = (modulus == W_ONE) ? W_ZERO : W_ONE;
          cnt_next_s  = shift_amt;
          acc_next_s  = W_ZERO;
          k_next_s    = K_ZERO;
          if (reject_s) begin
            state_next_s = ST_DONE;
          end else if (shift_amt != C_ZERO) begin
            state_next_s = ST_DOUBLE;
          end else begin
            state_next_s = ST_EMIT;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_DOUBLE: begin
        base_next_s = mod_reduce({base_r, 1'b0}, mod_r);
        cnt_next_s  = cnt_r - C_ONE;
        acc_next_s  = W_ZERO;
        k_next_s    = K_ZERO;
        if (cnt_r == C_ONE) begin
          state_next_s = ST_EMIT;
        end else begin
          state_next_s = ST_DOUBLE;
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          if (k_r == K_LAST) begin
            state_next_s = ST_DONE;
          end else begin
            k_next_s   = k_r + K_ONE;
            acc_next_s = mod_reduce({1'b0, acc_r} + {1'b0, base_r}, mod_r);
          end
        end else begin
          state_next_s = ST_EMIT;
        end
      end
      ST_DONE: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      mod_r     <= W_ZERO;
      base_r    <= W_ZERO;
      acc_r     <= W_ZERO;
      k_r       <= K_ZERO;
      cnt_r     <= C_ZERO;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_index <= K_ZERO;
      out_data  <= W_ZERO;
      done      <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      mod_r     <= mod_next_s;
      base_r    <= base_next_s;
      acc_r     <= acc_next_s;
      k_r       <= k_next_s;
      cnt_r     <= cnt_next_s;
      busy      <= (state_next_s == ST_DOUBLE) || (state_next_s == ST_EMIT);
      out_valid <= (state_next_s == ST_EMIT);
      out_index <= (state_next_s == ST_EMIT) ? k_next_s : K_ZERO;
      out_data  <= (state_next_s == ST_EMIT) ? acc_next_s : W_ZERO;
      done      <= (state_next_s == ST_DONE);
    end
  end

`ifdef XPB_GEN_MOD_CHECK_EN
  logic err_r;

  // Error flag accompanies the done pulse of a rejected start only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else begin
      err_r <= (state_r == ST_IDLE) && start && reject_s;
    end
  end

  assign err = err_r;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_xpb_table_gen.sv
// Self-checking bench for xpb_table_gen at WIDTH=16: vector table plus random moduli/shifts,
// random backpressure, start-while-busy and mid-run reset sequences.
module tb_xpb_table_gen;
  localparam int W  = 16;
  localparam int DB = 5;
  localparam int SW = 11;
  localparam int NE = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  modulus;
  logic [SW-1:0] shift_amt;
  logic          busy, out_valid, out_ready, done, err;
  logic [DB-1:0] out_index;
  logic [W-1:0]  out_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] n;
    int           s;
    bit           rnd_ready;
    bit           poke;
    int           exp_lat;
    logic [W-1:0] exp_last;
  } vec_t;

  vec_t vecs[10];

  xpb_table_gen #(.WIDTH(W), .DIGIT_BITS(DB), .SHIFT_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .modulus(modulus), .shift_amt(shift_amt),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
    .out_data(out_data), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: entry k = k * (2^s mod N) mod N, built with plain integer arithmetic.
  task automatic run_vec(input vec_t v);
    longint       p;
    logic [W-1:0] exp_e[NE];
    int           idx, cyc;
    bit           got_valid, want_done, finished, rdy;
    p = 1 % longint'(v.n);
    for (int i = 0; i < v.s; i++) p = (p * 2) % longint'(v.n);
    for (int k = 0; k < NE; k++) exp_e[k] = W'((longint'(k) * p) % longint'(v.n));
    idx = 0; cyc = 0; got_valid = 0; want_done = 0; finished = 0;
    start = 1'b1; modulus = v.n; shift_amt = SW'(v.s); out_ready = 1'b1;
    while (!finished && cyc < v.s + 400) begin
      tick();
      cyc++;
      start = 1'b0;
      if (cyc == 1) begin
        chk("busy_after_start", busy, 1);
        chk("valid_at_cycle1", out_valid, (v.s == 0));
      end
      chk("err_low", err, 0);
      if (want_done) begin
        chk("done_pulse", done, 1);
        chk("done_not_busy", busy, 0);
        chk("done_no_valid", out_valid, 0);
        chk("done_count", idx, NE);
        finished = 1;
      end else begin
        chk("no_early_done", done, 0);
        chk("busy_active", busy, 1);
        rdy = v.rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        out_ready = rdy;
        if (out_valid) begin
          if (!got_valid) begin
            chk("first_valid_latency", cyc, v.exp_lat);
            got_valid = 1;
          end
          if (idx >= NE) begin
            chk("extra_entry", out_valid, 0);
          end else begin
            chk("index", out_index, idx);
            chk("data", out_data, exp_e[idx]);
            if (idx == NE - 1) chk("last_data", out_data, v.exp_last);
            if (v.poke && idx == 5) begin
              start = 1'b1; modulus = 16'h0003; shift_amt = 11'd1;
            end
            if (rdy) begin
              if (idx == NE - 1) want_done = 1;
              idx++;
            end
          end
        end
      end
    end
    if (!finished) begin
      checks++;
      errors++;
      $display("FAIL timeout: reached entry %0d of %0d without done", idx, NE);
    end
    out_ready = 1'b1;
    tick();
    chk("done_one_cycle", done, 0);
    chk("idle_not_busy", busy, 0);
    chk("idle_no_valid", out_valid, 0);
  endtask

  initial begin
    vec_t r;
    longint p;
    vecs[0] = '{n: 16'hFFF1, s: 16, rnd_ready: 0, poke: 0, exp_lat: 17, exp_last: 16'h01D1};
    vecs[1] = '{n: 16'h0007, s: 3,  rnd_ready: 0, poke: 0, exp_lat: 4,  exp_last: 16'h0003};
    vecs[2] = '{n: 16'hFFF1, s: 16, rnd_ready: 1, poke: 0, exp_lat: 17, exp_last: 16'h01D1};
    vecs[3] = '{n: 16'hFFF1, s: 0,  rnd_ready: 0, poke: 1, exp_lat: 1,  exp_last: 16'h001F};
    for (int i = 4; i < 10; i++) begin
      r.n = W'($urandom_range(2, 65535));
      r.s = int'($urandom_range(0, 40));
      r.rnd_ready = 1'($urandom_range(0, 1));
      r.poke = (i == 5);
      r.exp_lat = r.s + 1;
      p = 1;
      for (int j = 0; j < r.s; j++) p = (p * 2) % longint'(r.n);
      r.exp_last = W'((31 * p) % longint'(r.n));
      vecs[i] = r;
    end

    rst_n = 1'b0; start = 1'b0; modulus = '0; shift_amt = '0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_index", out_index, 0);
    chk("rst_data", out_data, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Reset in the middle of the doubling phase.
    start = 1'b1; modulus = 16'hFFF1; shift_amt = 11'd16;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("mid_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_busy", busy, 0);
    chk("async_valid", out_valid, 0);
    chk("async_done", done, 0);
    chk("async_data", out_data, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("post_rst_no_valid", out_valid, 0);
      chk("post_rst_not_busy", busy, 0);
    end
    run_vec(vecs[0]);

    // Reset while entries are being emitted.
    start = 1'b1; modulus = 16'h0007; shift_amt = 11'd0;
    tick();
    start = 1'b0;
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    chk("emit_rst_valid", out_valid, 0);
    chk("emit_rst_index", out_index, 0);
    tick();
    rst_n = 1'b1;
    tick();
    run_vec(vecs[1]);

`ifdef XPB_GEN_MOD_CHECK_EN
    start = 1'b1; modulus = 16'h0001; shift_amt = 11'd5;
    tick();
    start = 1'b0;
    chk("chk_done", done, 1);
    chk("chk_err", err, 1);
    chk("chk_busy", busy, 0);
    chk("chk_valid", out_valid, 0);
    tick();
    chk("chk_done_clear", done, 0);
    chk("chk_err_clear", err, 0);
    chk("chk_busy_idle", busy, 0);
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
